// File: rtl/pipe_stage_chain.sv
// Falling-edge pipeline of DEPTH data/valid stages with global stall, per-stage flush,
// population-count occupancy and a saturating counter of consecutive stalled edges.
module pipe_stage_chain #(
   parameter int               WIDTH = 32,
   parameter int               DEPTH = 3,
   parameter logic [WIDTH-1:0] NOP   = '0,
   localparam int              OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_bar,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [DEPTH-1:0] flush,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [DEPTH-1:0] stage_valid,
   output logic [OCC_W-1:0] occupancy,
   output logic [7:0]       stall_cnt
);

   logic [WIDTH-1:0] stage_data [DEPTH];

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_stage
         logic [WIDTH-1:0] src_data;
         logic             src_valid;
         logic [WIDTH-1:0] data_q;
         logic             valid_q;

         // Stage 0 turns an invalid input into a bubble so stray in_data never enters the pipe
         if (g == 0) begin : g_head
            assign src_data  = in_valid ? in_data : NOP;
            assign src_valid = in_valid;
         end else begin : g_body
            assign src_data  = stage_data[g-1];
            assign src_valid = stage_valid[g-1];
         end

         always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
               data_q  <= NOP;
               valid_q <= 1'b0;
            end else if (flush[g]) begin
               data_q  <= NOP;
               valid_q <= 1'b0;
            end else if (!enable_bar) begin
               data_q  <= src_data;
               valid_q <= src_valid;
            end
         end

         assign stage_data[g]  = data_q;
         assign stage_valid[g] = valid_q;
      end
   endgenerate

   assign out_data  = stage_data[DEPTH-1];
   assign out_valid = stage_valid[DEPTH-1];

   // Counts back-to-back stalled edges; flush has no say in it
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 8'd0;
      end else if (enable_bar) begin
         if (stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
         end
      end else begin
         stall_cnt <= 8'd0;
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(stage_valid[i]);
      end
   end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=8, DEPTH=3, NOP=0): directed scenarios
// plus randomized traffic compared against a stage-array model of the pipe rules.
module tb_pipe_stage_chain;

   localparam int W = 8;
   localparam int D = 3;

   logic         clk;
   logic         rst;
   logic         enable_bar;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic [D-1:0] flush;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic [D-1:0] stage_valid;
   logic [1:0]   occupancy;
   logic [7:0]   stall_cnt;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: one data/valid entry per stage plus the stall run length
   logic [W-1:0] m_data  [D];
   logic         m_valid [D];
   int           m_stall;

   pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .NOP(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable_bar  (enable_bar),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .flush       (flush),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .stage_valid (stage_valid),
      .occupancy   (occupancy),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic eb,
                                input logic [D-1:0] fl);
      in_valid   = v;
      in_data    = d;
      enable_bar = eb;
      flush      = fl;
   endtask

   task automatic model_clear();
      for (int i = 0; i < D; i++) begin
         m_data[i]  = '0;
         m_valid[i] = 1'b0;
      end
      m_stall = 0;
   endtask

   // Advances the model by one falling edge using the pre-edge stage contents
   task automatic model_edge();
      logic [W-1:0] od [D];
      logic         ov [D];
      if (rst) return;
      for (int i = 0; i < D; i++) begin
         od[i] = m_data[i];
         ov[i] = m_valid[i];
      end
      for (int i = 0; i < D; i++) begin
         if (flush[i]) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
         end else if (!enable_bar) begin
            if (i == 0) begin
               m_data[i]  = in_valid ? in_data : '0;
               m_valid[i] = in_valid;
            end else begin
               m_data[i]  = od[i-1];
               m_valid[i] = ov[i-1];
            end
         end
      end
      m_stall = enable_bar ? ((m_stall >= 255) ? 255 : m_stall + 1) : 0;
   endtask

   task automatic tick();
      @(negedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic fill_10_11_12();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, W'(10 + i), 1'b0, '0);
         tick();
      end
   endtask

   task automatic test_reset();
      n_compared++;
      if (out_data !== 8'd0 || out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_out: got data=%0d valid=%0b expected 0/0", out_data, out_valid);
      end
      n_compared++;
      if (stage_valid !== 3'b000 || occupancy !== 2'd0 || stall_cnt !== 8'd0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_state: got sv=%b occ=%0d sc=%0d expected 000/0/0",
                  stage_valid, occupancy, stall_cnt);
      end
      applyStimulus(1'b1, 8'hAA, 1'b0, '0);
      tick();
      applyStimulus(1'b1, 8'hBB, 1'b1, '0);
      tick();
      n_compared++;
      if (stage_valid !== 3'b000 || stall_cnt !== 8'd0 || out_data !== 8'd0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_ignores_edges: got sv=%b sc=%0d data=%0d expected 000/0/0",
                  stage_valid, stall_cnt, out_data);
      end
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_stream();
      logic [1:0] exp_occ [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, W'(10 + i), 1'b0, '0);
         tick();
         n_compared++;
         if (occupancy !== exp_occ[i]) begin
            n_mismatched++;
            $display("[TB] FAIL stream_occ[%0d]: got %0d expected %0d", i, occupancy, exp_occ[i]);
         end
         if (i >= 2) begin
            n_compared++;
            if (out_data !== W'(8 + i) || out_valid !== 1'b1) begin
               n_mismatched++;
               $display("[TB] FAIL stream_out[%0d]: got %0d/%0b expected %0d/1",
                        i, out_data, out_valid, 8 + i);
            end
         end
      end
      applyStimulus(1'b0, 8'd0, 1'b0, '0);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_compared++;
         if (out_data !== W'(12 + i) || out_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL stream_tail[%0d]: got %0d/%0b expected %0d/1",
                     i, out_data, out_valid, 12 + i);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      fill_10_11_12();
      applyStimulus(1'b0, 8'h55, 1'b1, '0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_compared++;
         if (out_data !== 8'd10 || stage_valid !== 3'b111 || stall_cnt !== 8'(k)) begin
            n_mismatched++;
            $display("[TB] FAIL stall_hold[%0d]: got data=%0d sv=%b sc=%0d expected 10/111/%0d",
                     k, out_data, stage_valid, stall_cnt, k);
         end
      end
      applyStimulus(1'b0, 8'd0, 1'b0, '0);
      tick();
      n_compared++;
      if (stall_cnt !== 8'd0 || out_data !== 8'd11 || out_valid !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL stall_release: got sc=%0d data=%0d/%0b expected 0, 11/1",
                  stall_cnt, out_data, out_valid);
      end
      tick();
      n_compared++;
      if (out_data !== 8'd12 || out_valid !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL stall_resume: got %0d/%0b expected 12/1", out_data, out_valid);
      end
   endtask

   task automatic test_flush_priority();
      do_reset();
      fill_10_11_12();
      applyStimulus(1'b0, 8'd0, 1'b1, 3'b010);
      tick();
      n_compared++;
      if (stage_valid !== 3'b101 || occupancy !== 2'd2 || stall_cnt !== 8'd1 || out_data !== 8'd10) begin
         n_mismatched++;
         $display("[TB] FAIL flush_stall: got sv=%b occ=%0d sc=%0d data=%0d expected 101/2/1/10",
                  stage_valid, occupancy, stall_cnt, out_data);
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 3'b000);
      tick();
      n_compared++;
      if (out_data !== 8'd0 || out_valid !== 1'b0 || stage_valid !== 3'b010) begin
         n_mismatched++;
         $display("[TB] FAIL flush_bubble_moves: got %0d/%0b sv=%b expected 0/0 sv=010",
                  out_data, out_valid, stage_valid);
      end
      tick();
      n_compared++;
      if (out_data !== 8'd12 || out_valid !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL flush_survivor: got %0d/%0b expected 12/1", out_data, out_valid);
      end
   endtask

   task automatic test_bubble();
      logic [W-1:0] dv [5] = '{8'd20, 8'd99, 8'd22, 8'd0, 8'd0};
      logic         vv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] ed [3] = '{8'd20, 8'd0, 8'd22};
      logic         ev [3] = '{1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vv[i], dv[i], 1'b0, '0);
         tick();
         if (i >= 2) begin
            n_compared++;
            if (out_data !== ed[i-2] || out_valid !== ev[i-2]) begin
               n_mismatched++;
               $display("[TB] FAIL bubble_slot[%0d]: got %0d/%0b expected %0d/%0b",
                        i - 2, out_data, out_valid, ed[i-2], ev[i-2]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      fill_10_11_12();
      applyStimulus(1'b1, 8'd13, 1'b1, '0);
      tick();
      #2 rst = 1'b1;
      #1;
      n_compared++;
      if (out_data !== 8'd0 || out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 8'd0) begin
         n_mismatched++;
         $display("[TB] FAIL async_reset: got %0d/%0b occ=%0d sc=%0d expected 0/0/0/0",
                  out_data, out_valid, occupancy, stall_cnt);
      end
      #3 rst = 1'b0;
      model_clear();
      applyStimulus(1'b1, 8'h77, 1'b0, '0);
      tick();
      n_compared++;
      if (stage_valid !== 3'b001 || out_valid !== 1'b0 || stall_cnt !== 8'd0) begin
         n_mismatched++;
         $display("[TB] FAIL post_reset_edge: got sv=%b ov=%0b sc=%0d expected 001/0/0",
                  stage_valid, out_valid, stall_cnt);
      end
   endtask

   task automatic test_saturation();
      int mism = 0;
      do_reset();
      applyStimulus(1'b0, 8'd0, 1'b1, '0);
      for (int n = 1; n <= 300; n++) begin
         if (n == 290) flush = 3'b111;
         tick();
         n_compared++;
         if (stall_cnt !== 8'((n > 255) ? 255 : n)) begin
            n_mismatched++;
            mism++;
            if (mism <= 5)
               $display("[TB] FAIL stall_sat[%0d]: got %0d expected %0d",
                        n, stall_cnt, (n > 255) ? 255 : n);
         end
      end
      #2 rst = 1'b1;
      #1;
      n_compared++;
      if (stall_cnt !== 8'd0) begin
         n_mismatched++;
         $display("[TB] FAIL sat_reset: got %0d expected 0", stall_cnt);
      end
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_random();
      logic [D-1:0] exp_sv;
      int           exp_occ;
      int           mism = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         applyStimulus(($urandom % 4) != 0, W'($urandom), ($urandom % 4) == 0,
                       (($urandom % 5) == 0) ? D'($urandom) : '0);
         tick();
         exp_occ = 0;
         for (int i = 0; i < D; i++) begin
            exp_sv[i] = m_valid[i];
            exp_occ  += m_valid[i] ? 1 : 0;
         end
         n_compared++;
         if (out_data !== m_data[D-1] || out_valid !== m_valid[D-1] || stage_valid !== exp_sv ||
             occupancy !== 2'(exp_occ) || stall_cnt !== 8'(m_stall)) begin
            n_mismatched++;
            mism++;
            if (mism <= 5)
               $display("[TB] FAIL random[%0d]: got d=%0d v=%0b sv=%b occ=%0d sc=%0d expected d=%0d v=%0b sv=%b occ=%0d sc=%0d",
                        c, out_data, out_valid, stage_valid, occupancy, stall_cnt,
                        m_data[D-1], m_valid[D-1], exp_sv, exp_occ, m_stall);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      model_clear();
      applyStimulus(1'b0, 8'd0, 1'b0, '0);
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_flush_priority();
      test_bubble();
      test_async_reset();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
